register_dump_unit: RTL and testbench
=====================================

Name: register_dump_unit

Overview:
- Debug-side sequencer sitting directly downstream of the ID-stage register bank.
- While the pipeline is halted, it drives the bank's debug read port (read enable, read address) over all registers in order.
- Captures each returned word from the bank's port-A data output and serializes it byte by byte into the UART transmitter through a start/done handshake.
- Used by the debug unit to dump the register file to the host.

Parameters:
- DATA_SIZE, 32, width of one register word
- ADDR_SIZE, 5, width of the register address
- BANK_DEPTH, 32, number of registers dumped (addresses 0..BANK_DEPTH-1)
- BYTE_SIZE, 8, width of one UART byte; DATA_SIZE must be an integer multiple of it

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  dump request; sampled only in IDLE
- i_reg_data  in  DATA_SIZE  bank port-A read data; valid the cycle after o_read_enable
- i_tx_done  in  1  one-cycle pulse from UART tx when the current byte has been sent
- o_read_enable  out  1  to bank debug read enable
- o_read_addr  out  ADDR_SIZE  to bank debug read address
- o_tx_data  out  BYTE_SIZE  byte to UART tx; held stable from o_tx_start until i_tx_done
- o_tx_start  out  1  one-cycle pulse launching a UART byte
- o_busy  out  1  high from leaving IDLE until return to IDLE; the debug unit keeps the bank's pipeline enable low while this is high
- o_done  out  1  one-cycle pulse after the last byte of the last register is acknowledged

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; register index=0; byte counter=0; shift register=0.
- All outputs are registered. Internal counters: reg_idx (width $clog2(BANK_DEPTH)+1), byte_cnt (width $clog2(DATA_SIZE/BYTE_SIZE)+1).
- IDLE:
  - o_busy=0.
  - i_start=1 → REQ, reg_idx=0.
  - i_tx_done is ignored.
- REQ (1 cycle):
  - o_read_enable=1, o_read_addr=reg_idx.
  - Next state CAPTURE.
- CAPTURE (1 cycle):
  - o_read_enable=0.
  - The bank has latched the word on the edge ending REQ, so i_reg_data is valid here.
  - At the end of the cycle, load the shift register from i_reg_data and set byte_cnt=DATA_SIZE/BYTE_SIZE.
  - Next state SEND.
- SEND (1 cycle):
  - o_tx_start=1.
  - o_tx_data = shift register[BYTE_SIZE-1:0], so the least-significant byte goes first.
  - Next state WAIT_TX.
- WAIT_TX:
  - o_tx_start=0; o_tx_data held.
  - On i_tx_done: shift register >>= BYTE_SIZE, byte_cnt -= 1.
  - If byte_cnt was >1 → SEND.
  - Otherwise, if reg_idx==BANK_DEPTH-1 → DONE; else reg_idx += 1 → REQ.
  - Waits indefinitely with no timeout.
- DONE (1 cycle):
  - o_done=1, o_busy still 1.
  - Next state IDLE, with o_busy=0 in that cycle.
- Simultaneous events:
  - i_start while busy is ignored; no restart and no queueing.
  - i_tx_done outside WAIT_TX is ignored, including a pulse coincident with o_tx_start.
- Totals:
  - Byte count per dump = BANK_DEPTH*DATA_SIZE/BYTE_SIZE (128 with defaults).
  - Register order 0..BANK_DEPTH-1; little-endian within each word.
- Minimum latency:
  - i_start sampled at edge N → first o_tx_start at cycle N+3.
  - When i_tx_done arrives the cycle after SEND, each byte costs 2 cycles.
  - Each new register adds 2 cycles (REQ, CAPTURE).
- Reset mid-dump: the sequence is aborted immediately; no o_done. A later i_start begins again at register 0.

Test Plan:
- Reset/idle: assert i_reset mid-cycle → all outputs 0 asynchronously. Deassert, hold i_start=0, pulse i_tx_done → o_busy, o_tx_start, o_read_enable stay 0.
- Full dump: bank model with r[k]=0xA0000000|k, tx model returning i_tx_done 1 cycle after o_tx_start, pulse i_start → 128 bytes in order 0x00,0x00,0x00,0xA0, 0x01,0x00,0x00,0xA0, …, 0x1F,0x00,0x00,0xA0. Also check o_read_addr 0..31 with each o_read_enable exactly 1 cycle, one o_done pulse after the 128th i_tx_done, and the first o_tx_start 3 cycles after i_start.
- Slow UART: i_tx_done returned 10 cycles after each start, r[5]=0xDEADBEEF → bytes EF,BE,AD,DE for register 5; o_tx_data constant throughout each wait; no extra o_tx_start.
- Start while busy: pulse i_start at byte 7 → no restart; total still 128 bytes; single o_done.
- Reset mid-dump: i_reset during WAIT_TX of register 3 → IDLE, o_busy=0, no o_done. New i_start → o_read_addr starts at 0.
- Back-to-back: i_start in the cycle after o_done → second full dump identical to the first.

Source files
------------

// File: rtl/register_dump_unit.sv
// Walks the register bank's debug read port and streams every word, LSB first, to the UART tx.
// First byte launches 3 cycles after i_start; stalls indefinitely in WAIT_TX until i_tx_done.
module register_dump_unit #(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_SIZE  = 5,
  parameter int BANK_DEPTH = 32,
  parameter int BYTE_SIZE  = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_SIZE-1:0] i_reg_data,
  input  logic                 i_tx_done,
  output logic                 o_read_enable,
  output logic [ADDR_SIZE-1:0] o_read_addr,
  output logic [BYTE_SIZE-1:0] o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BYTES_PER_WORD = DATA_SIZE / BYTE_SIZE;
  localparam int IDX_W          = $clog2(BANK_DEPTH) + 1;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BANK_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAPTURE,
    S_SEND,
    S_WAIT_TX,
    S_DONE
  } state_t;

  state_t               state, state_nx;
  logic [IDX_W-1:0]     reg_idx, reg_idx_nx;
  logic [CNT_W-1:0]     byte_cnt, byte_cnt_nx;
  logic [DATA_SIZE-1:0] shift_q, shift_nx;

  always_comb begin
    state_nx    = state;
    reg_idx_nx  = reg_idx;
    byte_cnt_nx = byte_cnt;
    shift_nx    = shift_q;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nx   = S_REQ;
          reg_idx_nx = '0;
        end
      end
      S_REQ: state_nx = S_CAPTURE;
      S_CAPTURE: begin
        // The bank registered the word on the edge that ended REQ.
        shift_nx    = i_reg_data;
        byte_cnt_nx = FULL_CNT;
        state_nx    = S_SEND;
      end
      S_SEND: state_nx = S_WAIT_TX;
      S_WAIT_TX: begin
        if (i_tx_done) begin
          shift_nx    = shift_q >> BYTE_SIZE;
          byte_cnt_nx = byte_cnt - ONE_CNT;
          if (byte_cnt > ONE_CNT) begin
            state_nx = S_SEND;
          end else if (reg_idx == LAST_IDX) begin
            state_nx = S_DONE;
          end else begin
            reg_idx_nx = reg_idx + IDX_W'(1);
            state_nx   = S_REQ;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      reg_idx  <= '0;
      byte_cnt <= '0;
      shift_q  <= '0;
    end else begin
      state    <= state_nx;
      reg_idx  <= reg_idx_nx;
      byte_cnt <= byte_cnt_nx;
      shift_q  <= shift_nx;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_read_enable <= 1'b0;
      o_read_addr   <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_read_enable <= (state_nx == S_REQ);
      o_tx_start    <= (state_nx == S_SEND);
      o_done        <= (state_nx == S_DONE);
      o_busy        <= (state_nx != S_IDLE);
      if (state_nx == S_REQ) begin
        o_read_addr <= ADDR_SIZE'(reg_idx_nx);
      end
      if (state_nx == S_SEND) begin
        o_tx_data <= shift_nx[BYTE_SIZE-1:0];
      end
    end
  end

endmodule

// File: tb/tb_register_dump_unit.sv
// Directed bench for register_dump_unit: bank and UART tx models plus a byte/address monitor.
module tb_register_dump_unit;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [31:0] i_reg_data;
  logic        i_tx_done;
  logic        o_read_enable;
  logic [4:0]  o_read_addr;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        o_busy;
  logic        o_done;

  register_dump_unit dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_reg_data    (i_reg_data),
    .i_tx_done     (i_tx_done),
    .o_read_enable (o_read_enable),
    .o_read_addr   (o_read_addr),
    .o_tx_data     (o_tx_data),
    .o_tx_start    (o_tx_start),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 i_clock = ~i_clock;

  // Register bank: read port registers the word on the edge that ends the read-enable cycle.
  logic [31:0] mem [32];
  logic [31:0] bank_q;
  always @(posedge i_clock) if (o_read_enable) bank_q <= mem[o_read_addr];
  assign i_reg_data = bank_q;

  // UART tx: pulses done tx_delay cycles after the start cycle; tx_early adds a spurious pulse during start.
  int   tx_delay = 1;
  bit   tx_early = 0;
  int   tx_cnt   = 0;
  logic tx_model_done = 1'b0;
  logic tx_manual_done;
  assign i_tx_done = tx_model_done | tx_manual_done;

  always @(negedge i_clock) begin
    if (o_tx_start) begin
      tx_cnt        = tx_delay;
      tx_model_done = tx_early;
    end else if (tx_cnt > 0) begin
      tx_cnt        = tx_cnt - 1;
      tx_model_done = (tx_cnt == 0);
    end else begin
      tx_model_done = 1'b0;
    end
  end

  // Monitor
  logic [7:0] bytes_q [$];
  logic [4:0] addr_q  [$];
  int   done_cnt = 0, re_err = 0, stab_err = 0;
  logic prev_re  = 1'b0;
  logic [7:0] held;
  bit   have_byte = 0;

  always @(negedge i_clock) begin
    if (o_read_enable) begin
      addr_q.push_back(o_read_addr);
      if (prev_re) re_err++;
    end
    prev_re = o_read_enable;
    if (o_done) done_cnt++;
    if (!o_busy) have_byte = 0;
    if (o_tx_start) begin
      bytes_q.push_back(o_tx_data);
      held      = o_tx_data;
      have_byte = 1;
    end else if (o_busy && have_byte && o_tx_data !== held) begin
      stab_err++;
    end
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_dump(input bit aligned, input bit mid_start, input bit abort,
                         output int cyc, output int first_tx);
    int  base;
    bit  injected;
    base     = bytes_q.size();
    cyc      = 0;
    first_tx = -1;
    injected = 0;
    if (aligned) @(negedge i_clock);
    i_start = 1'b1;
    while (cyc < 4000) begin
      @(posedge i_clock); #1;
      cyc++;
      i_start = 1'b0;
      if (mid_start && !injected && (bytes_q.size() - base) == 7) begin
        i_start  = 1'b1;
        injected = 1;
      end
      if (first_tx < 0 && o_tx_start) first_tx = cyc;
      if (o_done) break;
      if (abort && (bytes_q.size() - base) == 14 && !o_tx_start) break;
    end
    i_start = 1'b0;
  endtask

  task automatic check_dump(input string tag, input int bb, input int ab);
    logic [31:0] w;
    check({tag, "_nbytes"}, 32'(bytes_q.size() - bb), 32'd128);
    check({tag, "_naddr"},  32'(addr_q.size() - ab),  32'd32);
    if (bytes_q.size() - bb >= 128) begin
      for (int k = 0; k < 32; k++) begin
        w = mem[k];
        for (int j = 0; j < 4; j++)
          check($sformatf("%s_r%0d_b%0d", tag, k, j), 32'(bytes_q[bb + 4*k + j]), (w >> (8*j)) & 32'hFF);
      end
    end
    if (addr_q.size() - ab >= 32) begin
      for (int k = 0; k < 32; k++)
        check($sformatf("%s_addr%0d", tag, k), 32'(addr_q[ab + k]), 32'(k));
    end
  endtask

  task automatic post_done(input string tag, input int dc);
    @(posedge i_clock); #1;
    check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    check({tag, "_done_cnt"},   32'(done_cnt - dc), 32'd1);
  endtask

  int cyc, first_tx, bb, ab, dc;

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    tx_manual_done = 1'b0;
    for (int k = 0; k < 32; k++) mem[k] = 32'hA000_0000 | 32'(k);

    // Reset applied before any clock edge: outputs must already be zero.
    #3;
    check("rst_busy",  32'(o_busy), 0);
    check("rst_start", 32'(o_tx_start), 0);
    check("rst_re",    32'(o_read_enable), 0);
    check("rst_done",  32'(o_done), 0);
    check("rst_data",  32'(o_tx_data), 0);
    check("rst_addr",  32'(o_read_addr), 0);
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;

    // Idle: stray tx_done must not wake the unit.
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clock); tx_manual_done = 1'b1;
      @(posedge i_clock); #1;
      check("idle_busy",  32'(o_busy), 0);
      check("idle_start", 32'(o_tx_start), 0);
      check("idle_re",    32'(o_read_enable), 0);
    end
    @(negedge i_clock); tx_manual_done = 1'b0;
    repeat (2) @(negedge i_clock);

    // Full dump, fast UART: 32 regs * (2 + 4*2) cycles + DONE.
    bb = bytes_q.size(); ab = addr_q.size(); dc = done_cnt;
    do_dump(1, 0, 0, cyc, first_tx);
    check("full_first_tx", 32'(first_tx), 32'd3);
    check("full_cycles",   32'(cyc), 32'd321);
    check("full_b0", 32'(bytes_q[bb]),     32'h00);
    check("full_b3", 32'(bytes_q[bb + 3]), 32'hA0);
    check("full_b4", 32'(bytes_q[bb + 4]), 32'h01);
    check("full_b124", 32'(bytes_q[bb + 124]), 32'h1F);
    check_dump("full", bb, ab);
    post_done("full", dc);
    check("full_re_err", 32'(re_err), 0);

    // Slow UART with a spurious done coincident with each start.
    mem[5] = 32'hDEAD_BEEF;
    tx_delay = 10; tx_early = 1;
    repeat (3) @(negedge i_clock);
    bb = bytes_q.size(); ab = addr_q.size(); dc = done_cnt;
    do_dump(1, 0, 0, cyc, first_tx);
    check("slow_cycles", 32'(cyc), 32'd1473);
    check("slow_r5_b0", 32'(bytes_q[bb + 20]), 32'hEF);
    check("slow_r5_b1", 32'(bytes_q[bb + 21]), 32'hBE);
    check("slow_r5_b2", 32'(bytes_q[bb + 22]), 32'hAD);
    check("slow_r5_b3", 32'(bytes_q[bb + 23]), 32'hDE);
    check_dump("slow", bb, ab);
    post_done("slow", dc);
    check("slow_stable", 32'(stab_err), 0);
    tx_delay = 1; tx_early = 0;

    // Start while busy is ignored.
    repeat (3) @(negedge i_clock);
    bb = bytes_q.size(); ab = addr_q.size(); dc = done_cnt;
    do_dump(1, 1, 0, cyc, first_tx);
    check("busy_start_cycles", 32'(cyc), 32'd321);
    check_dump("busy_start", bb, ab);
    post_done("busy_start", dc);

    // Reset while waiting on register 3's second byte.
    tx_delay = 10;
    repeat (3) @(negedge i_clock);
    dc = done_cnt;
    do_dump(1, 0, 1, cyc, first_tx);
    check("abort_in_wait", 32'(o_busy), 32'd1);
    #2 i_reset = 1'b1;
    #1;
    check("abort_busy",  32'(o_busy), 0);
    check("abort_re",    32'(o_read_enable), 0);
    check("abort_start", 32'(o_tx_start), 0);
    check("abort_data",  32'(o_tx_data), 0);
    @(negedge i_clock); i_reset = 1'b0;
    tx_delay = 1;
    repeat (20) @(posedge i_clock);
    #1;
    check("abort_no_done", 32'(done_cnt - dc), 0);
    check("abort_idle",    32'(o_busy), 0);

    // Restart after abort, then a back-to-back dump started in the cycle after o_done.
    bb = bytes_q.size(); ab = addr_q.size(); dc = done_cnt;
    do_dump(1, 0, 0, cyc, first_tx);
    check("restart_cycles", 32'(cyc), 32'd321);
    check_dump("restart", bb, ab);
    post_done("restart", dc);
    bb = bytes_q.size(); ab = addr_q.size(); dc = done_cnt;
    do_dump(0, 0, 0, cyc, first_tx);
    check("b2b_cycles", 32'(cyc), 32'd321);
    check_dump("b2b", bb, ab);
    post_done("b2b", dc);
    check("final_re_err", 32'(re_err), 0);
    check("final_stable", 32'(stab_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
